// File: rtl/mips_defs.sv
// Shared MIPS definitions: memory opcodes, MEM/WB field widths and a small
// decoder that classifies an opcode into load/store, access size and signedness.
package mips_defs;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int DATA_W  = 32;
    localparam int WA_W    = 5;
    localparam int IMM_W   = 32;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } acc_size_e;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        logic      sign_ext;
        acc_size_e size;
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(input logic [5:0] op);
        mem_op_t d;
        d.is_load  = 1'b0;
        d.is_store = 1'b0;
        d.sign_ext = 1'b0;
        d.size     = SZ_NONE;
        case (op)
            OP_LW:  begin d.is_load  = 1'b1; d.size = SZ_WORD; end
            OP_LB:  begin d.is_load  = 1'b1; d.size = SZ_BYTE; d.sign_ext = 1'b1; end
            OP_LBU: begin d.is_load  = 1'b1; d.size = SZ_BYTE; end
            OP_LH:  begin d.is_load  = 1'b1; d.size = SZ_HALF; d.sign_ext = 1'b1; end
            OP_LHU: begin d.is_load  = 1'b1; d.size = SZ_HALF; end
            OP_SW:  begin d.is_store = 1'b1; d.size = SZ_WORD; end
            OP_SB:  begin d.is_store = 1'b1; d.size = SZ_BYTE; end
            OP_SH:  begin d.is_store = 1'b1; d.size = SZ_HALF; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: captures every field on each rising edge, cleared
// asynchronously by reset.
module mem_wb
    import mips_defs::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    PC3,
    input  logic [INSTR_W-1:0] Instr3,
    input  logic [DATA_W-1:0]  Result3,
    input  logic [DATA_W-1:0]  mem_rd,
    input  logic [WA_W-1:0]    WA3,
    input  logic [IMM_W-1:0]   imm32_3,
    input  logic               adel,
    input  logic               ades,
    output logic [PC_W-1:0]    PC4,
    output logic [INSTR_W-1:0] Instr4,
    output logic [DATA_W-1:0]  ALURes4,
    output logic [DATA_W-1:0]  MemRD4,
    output logic [WA_W-1:0]    WA4,
    output logic [IMM_W-1:0]   imm32_4,
    output logic               AdEL4,
    output logic               AdES4
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC4     <= '0;
            Instr4  <= '0;
            ALURes4 <= '0;
            MemRD4  <= '0;
            WA4     <= '0;
            imm32_4 <= '0;
            AdEL4   <= 1'b0;
            AdES4   <= 1'b0;
        end else begin
            PC4     <= PC3;
            Instr4  <= Instr3;
            ALURes4 <= Result3;
            MemRD4  <= mem_rd;
            WA4     <= WA3;
            imm32_4 <= imm32_3;
            AdEL4   <= adel;
            AdES4   <= ades;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: word-organised data memory with byte/half/word access,
// load extension, WB->MEM store-data forwarding and the MEM/WB register.
module memory_stage
    import mips_defs::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC3,
    input  logic [31:0] Instr3,
    input  logic [31:0] Result3,
    input  logic [31:0] B3,
    input  logic [4:0]  WA3,
    input  logic [31:0] imm32_3,
    input  logic        ForwardRTM,
    input  logic [31:0] WD,
    output logic [31:0] PC4,
    output logic [31:0] Instr4,
    output logic [31:0] ALURes4,
    output logic [31:0] MemRD4,
    output logic [4:0]  WA4,
    output logic [31:0] imm32_4,
    output logic        AdEL4,
    output logic        AdES4
);

    logic [31:0]      dm_mem [DM_WORDS];
    mem_op_t          dec;
    logic [DM_AW-1:0] word_idx;
    logic [1:0]       lane;
    logic [31:0]      sd;
    logic [31:0]      rd_word;
    logic [31:0]      sd_lanes;
    logic [31:0]      wr_word;
    logic [3:0]       lane_we;
    logic             misaligned;
    logic             adel;
    logic             ades;
    logic             store_en;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      mem_rd;
    logic             unused_addr_bits;

    assign dec      = decode_mem_op(Instr3[31:26]);
    assign word_idx = Result3[DM_AW+1:2];
    assign lane     = Result3[1:0];
    assign sd       = ForwardRTM ? WD : B3;
    assign rd_word  = dm_mem[word_idx];

    // Address bits above the array simply wrap.
    assign unused_addr_bits = ^Result3[31:DM_AW+2];

    always_comb begin
        misaligned = 1'b0;
        case (dec.size)
            SZ_WORD: misaligned = |lane;
            SZ_HALF: misaligned = lane[0];
            default: misaligned = 1'b0;
        endcase
    end

    assign adel     = dec.is_load & misaligned;
    assign ades     = dec.is_store & misaligned;
    assign store_en = dec.is_store & ~misaligned;

    // Replicate the store data across lanes so each lane enable just picks it up.
    always_comb begin
        sd_lanes = sd;
        lane_we  = 4'b0000;
        case (dec.size)
            SZ_WORD: begin
                sd_lanes = sd;
                lane_we  = 4'b1111;
            end
            SZ_HALF: begin
                sd_lanes = {2{sd[15:0]}};
                lane_we  = lane[1] ? 4'b1100 : 4'b0011;
            end
            SZ_BYTE: begin
                sd_lanes = {4{sd[7:0]}};
                lane_we  = 4'b0001 << lane;
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_word[8*gi +: 8] = lane_we[gi] ? sd_lanes[8*gi +: 8] : rd_word[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_mem[i] <= '0;
            end
        end else if (store_en) begin
            dm_mem[word_idx] <= wr_word;
        end
    end

    assign rd_byte = rd_word[8*lane +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        mem_rd = '0;
        if (dec.is_load && !misaligned) begin
            case (dec.size)
                SZ_WORD: mem_rd = rd_word;
                SZ_HALF: mem_rd = dec.sign_ext ? {{16{rd_half[15]}}, rd_half}
                                               : {16'h0000, rd_half};
                SZ_BYTE: mem_rd = dec.sign_ext ? {{24{rd_byte[7]}}, rd_byte}
                                               : {24'h000000, rd_byte};
                default: mem_rd = '0;
            endcase
        end
    end

    mem_wb u_mem_wb (
        .clk     (clk),
        .reset   (reset),
        .PC3     (PC3),
        .Instr3  (Instr3),
        .Result3 (Result3),
        .mem_rd  (mem_rd),
        .WA3     (WA3),
        .imm32_3 (imm32_3),
        .adel    (adel),
        .ades    (ades),
        .PC4     (PC4),
        .Instr4  (Instr4),
        .ALURes4 (ALURes4),
        .MemRD4  (MemRD4),
        .WA4     (WA4),
        .imm32_4 (imm32_4),
        .AdEL4   (AdEL4),
        .AdES4   (AdES4)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random traffic checked
// against a byte-addressed reference memory.
module tb_memory_stage;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PC3 = '0;
    logic [31:0] Instr3 = '0;
    logic [31:0] Result3 = '0;
    logic [31:0] B3 = '0;
    logic [4:0]  WA3 = '0;
    logic [31:0] imm32_3 = '0;
    logic        ForwardRTM = 1'b0;
    logic [31:0] WD = '0;
    logic [31:0] PC4, Instr4, ALURes4, MemRD4, imm32_4;
    logic [4:0]  WA4;
    logic        AdEL4, AdES4;

    always #5 clk = ~clk;

    memory_stage #(.DM_WORDS(1024), .DM_AW(10)) dut (
        .clk(clk), .reset(reset),
        .PC3(PC3), .Instr3(Instr3), .Result3(Result3), .B3(B3), .WA3(WA3),
        .imm32_3(imm32_3), .ForwardRTM(ForwardRTM), .WD(WD),
        .PC4(PC4), .Instr4(Instr4), .ALURes4(ALURes4), .MemRD4(MemRD4),
        .WA4(WA4), .imm32_4(imm32_4), .AdEL4(AdEL4), .AdES4(AdES4)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] ref_mem [0:4095];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc4"},    PC4, 32'h0);
        check({tag, "_instr4"}, Instr4, 32'h0);
        check({tag, "_alures4"}, ALURes4, 32'h0);
        check({tag, "_memrd4"}, MemRD4, 32'h0);
        check({tag, "_wa4"},    {27'h0, WA4}, 32'h0);
        check({tag, "_imm4"},   imm32_4, 32'h0);
        check({tag, "_adel4"},  {31'h0, AdEL4}, 32'h0);
        check({tag, "_ades4"},  {31'h0, AdES4}, 32'h0);
    endtask

    // Drive one instruction for a cycle; expectations come from the byte model.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] b, input logic fwd, input logic [31:0] wd);
        logic [31:0] instr, pc, imm, exp_rd, sd;
        logic [4:0]  wa;
        int          a, size;
        bit          is_ld, is_st, sgn, aligned;
        instr = {op, 26'($urandom)};
        pc    = $urandom;
        imm   = $urandom;
        wa    = 5'($urandom);
        PC3 = pc; Instr3 = instr; Result3 = addr; B3 = b; WA3 = wa;
        imm32_3 = imm; ForwardRTM = fwd; WD = wd;

        is_ld = 0; is_st = 0; sgn = 0; size = 0;
        case (op)
            OP_LW:  begin is_ld = 1; size = 4; end
            OP_LB:  begin is_ld = 1; size = 1; sgn = 1; end
            OP_LBU: begin is_ld = 1; size = 1; end
            OP_LH:  begin is_ld = 1; size = 2; sgn = 1; end
            OP_LHU: begin is_ld = 1; size = 2; end
            OP_SW:  begin is_st = 1; size = 4; end
            OP_SB:  begin is_st = 1; size = 1; end
            OP_SH:  begin is_st = 1; size = 2; end
            default: ;
        endcase
        a       = int'(addr[11:0]);
        aligned = (size == 0) || (a % size == 0);
        sd      = fwd ? wd : b;

        exp_rd = 32'h0;
        if (is_ld && aligned) begin
            for (int k = 0; k < size; k++) exp_rd = exp_rd | (32'(ref_mem[a + k]) << (8 * k));
            if (sgn && size == 1 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFFFF00;
            if (sgn && size == 2 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF0000;
        end

        @(posedge clk);
        #1;
        check("pc4",     PC4, pc);
        check("instr4",  Instr4, instr);
        check("alures4", ALURes4, addr);
        check("wa4",     {27'h0, WA4}, {27'h0, wa});
        check("imm4",    imm32_4, imm);
        check("memrd4",  MemRD4, exp_rd);
        check("adel4",   {31'h0, AdEL4}, {31'h0, (is_ld && !aligned)});
        check("ades4",   {31'h0, AdES4}, {31'h0, (is_st && !aligned)});
        $display("[TB] op=%02h addr=%08h sd=%08h memrd4=%08h adel=%0d ades=%0d",
                 op, addr, sd, MemRD4, AdEL4, AdES4);

        if (is_st && aligned)
            for (int k = 0; k < size; k++) ref_mem[a + k] = 8'(sd >> (8 * k));
    endtask

    logic [5:0] op_tab [10];

    initial begin
        op_tab = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH, 6'b001000, 6'b000000};
        clear_ref();

        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // sw/lw round trip
        run_op(OP_SW, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        run_op(OP_LW, 32'h10, 32'h0, 1'b0, 32'h0);
        check("tp_lw_dead", MemRD4, 32'hDEADBEEF);
        check("tp_alures_10", ALURes4, 32'h10);

        // byte store over an existing word
        run_op(OP_SW,  32'h10, 32'h11223344, 1'b0, 32'h0);
        run_op(OP_SB,  32'h13, 32'h00000080, 1'b0, 32'h0);
        run_op(OP_LB,  32'h13, 32'h0, 1'b0, 32'h0);
        check("tp_lb_80", MemRD4, 32'hFFFFFF80);
        run_op(OP_LBU, 32'h13, 32'h0, 1'b0, 32'h0);
        check("tp_lbu_80", MemRD4, 32'h00000080);
        run_op(OP_LW,  32'h10, 32'h0, 1'b0, 32'h0);
        check("tp_lw_sb", MemRD4, 32'h80223344);

        // half store to upper lanes
        run_op(OP_SH,  32'h22, 32'h0000ABCD, 1'b0, 32'h0);
        run_op(OP_LH,  32'h22, 32'h0, 1'b0, 32'h0);
        check("tp_lh_abcd", MemRD4, 32'hFFFFABCD);
        run_op(OP_LHU, 32'h20, 32'h0, 1'b0, 32'h0);
        check("tp_lhu_lo", MemRD4, 32'h00000000);
        run_op(OP_LW,  32'h20, 32'h0, 1'b0, 32'h0);
        check("tp_lw_sh", MemRD4, 32'hABCD0000);

        // forwarded store data
        run_op(OP_SW, 32'h40, 32'h0, 1'b1, 32'h12345678);
        run_op(OP_LW, 32'h40, 32'h0, 1'b0, 32'h0);
        check("tp_fwd", MemRD4, 32'h12345678);

        // misaligned accesses
        run_op(OP_LW, 32'h41, 32'h0, 1'b0, 32'h0);
        check("tp_adel", {31'h0, AdEL4}, 32'h1);
        check("tp_adel_rd", MemRD4, 32'h0);
        run_op(OP_SH, 32'h43, 32'hFFFFFFFF, 1'b0, 32'h0);
        check("tp_ades", {31'h0, AdES4}, 32'h1);
        run_op(OP_LW, 32'h40, 32'h0, 1'b0, 32'h0);
        check("tp_ades_nowr", MemRD4, 32'h12345678);

        // address wrap: 0x1000 aliases word 0
        run_op(OP_SW, 32'h1000, 32'hCAFEF00D, 1'b0, 32'h0);
        run_op(OP_LW, 32'h0, 32'h0, 1'b0, 32'h0);
        check("tp_wrap", MemRD4, 32'hCAFEF00D);

        // reset between edges clears outputs at once and the memory
        run_op(OP_SW, 32'h8, 32'h55, 1'b0, 32'h0);
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        #2 reset = 1'b0;
        clear_ref();
        run_op(OP_LW, 32'h8, 32'h0, 1'b0, 32'h0);
        check("tp_reset_mem", MemRD4, 32'h0);
        run_op(OP_LW, 32'h0, 32'h0, 1'b0, 32'h0);
        check("tp_reset_wrap", MemRD4, 32'h0);

        // random traffic over a small window, sometimes with high address bits set
        for (int n = 0; n < 300; n++) begin
            logic [31:0] addr;
            addr = 32'($urandom_range(0, 95));
            if ($urandom_range(0, 7) == 0) addr = addr | ($urandom & 32'hFFFFF000);
            run_op(op_tab[$urandom_range(0, 9)], addr, $urandom,
                   1'($urandom_range(0, 1)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Fourth pipeline stage of the 5-stage MIPS core. Consumes the EX/MEM register outputs (PC3, Instr3, Result3, B3, WA3, imm32_3) directly from the Execution stage.
- Holds the word-organised data memory. Performs aligned word/half/byte loads and stores, with sign/zero extension applied to loads.
- Applies WB→MEM forwarding on the store data.
- Registers everything into an internal MEM/WB pipeline register that feeds Writeback.

Parameters:
- DM_WORDS, 1024, data memory depth in 32-bit words (power of two).
- DM_AW, 10, word-index width = log2(DM_WORDS).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears MEM/WB register and data memory
- PC3  in  32  PC of instruction in MEM
- Instr3  in  32  instruction in MEM
- Result3  in  32  ALU result = byte address for loads/stores
- B3  in  32  rt value from EX/MEM (store data before forwarding)
- WA3  in  5  destination register
- imm32_3  in  32  extended immediate, passed through
- ForwardRTM  in  1  0: store data = B3; 1: store data = WD
- WD  in  32  Writeback-stage write data (forward source)
- PC4  out  32  registered PC3
- Instr4  out  32  registered Instr3
- ALURes4  out  32  registered Result3
- MemRD4  out  32  registered, extended load data (0 for non-loads)
- WA4  out  5  registered WA3
- imm32_4  out  32  registered imm32_3
- AdEL4  out  1  registered misaligned-load flag
- AdES4  out  1  registered misaligned-store flag

Behaviour:
- Decode from Instr3[31:26]:
  - loads: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101
  - stores: sw 101011, sb 101000, sh 101001
  - all other opcodes: no memory access.
- Addressing: word index = Result3[DM_AW+1:2]; byte lane = Result3[1:0]. Little-endian: lane 0 = bits [7:0]. Upper address bits beyond DM_AW+2 are ignored, so addresses wrap modulo DM_WORDS*4.
- Store data SD = ForwardRTM ? WD : B3.
- Alignment rules:
  - lw/sw require Result3[1:0]=00.
  - lh/lhu/sh require Result3[0]=0.
  - byte ops are always aligned.
- Misaligned access:
  - A misaligned store performs no write and raises AdES.
  - A misaligned load raises AdEL and loads 0 into MemRD4.
- Memory read: combinational from the array at the word index.
- Load extraction:
  - lw: full word.
  - lb/lbu: selected byte, sign/zero-extended.
  - lh/lhu: half at lane 0 or 2, sign/zero-extended.
- Memory write happens on rising clk for stores:
  - sw writes the whole word.
  - sh writes lanes {1,0} or {3,2} with SD[15:0].
  - sb writes a single lane with SD[7:0].
  - Unselected lanes keep their old value (read-modify-write within the same edge).
- MEM/WB register: on each rising clk, PC4/Instr4/ALURes4/WA4/imm32_4 capture their stage inputs, and MemRD4/AdEL4/AdES4 capture the computed values.
  - Latency is exactly 1 cycle.
  - No stall or flush inputs: the stage advances every cycle.
- Read-after-write to the same address in consecutive instructions: a load in cycle N+1 sees data stored at edge N. The store commits on the same edge the store moves to WB.
- Reset (asserted at any time, including mid-operation):
  - All MEM/WB outputs go to 0 immediately.
  - All DM_WORDS entries are cleared to 0.
  - Any store in flight at that edge is discarded.
  - After deassertion, normal operation resumes on the next rising edge.
- Simultaneous reset and store: reset wins.

Decomposition:
- Shared package (mips_defs): opcode localparams (OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH) and the MEM/WB field widths.
- One sub-module, mem_wb, holds the MEM/WB register: asynchronous clear, 8 captured fields.
- Data memory array, byte-lane logic and load extension live in memory_stage.

Test Plan:
- sw at Result3=0x10 with B3=0xDEADBEEF, then lw 0x10 → MemRD4=0xDEADBEEF one cycle after the lw; ALURes4=0x10.
- sb of 0x80 to 0x13 over word 0x11223344, then lb 0x13 → 0xFFFFFF80, lbu 0x13 → 0x00000080; word reads 0x80223344.
- sh 0xABCD to 0x22 over 0, then lh 0x22 → 0xFFFFABCD, lhu 0x20 → 0x00000000; lw 0x20 → 0xABCD0000.
- sw with ForwardRTM=1, WD=0x12345678, B3=0x0 at 0x40; lw 0x40 → 0x12345678.
- lw at 0x41 → AdEL4=1, MemRD4=0; sh at 0x43 → AdES4=1 and a later lw at 0x40 still returns the prior value.
- Reset pulse asserted between clock edges after storing 0x55 at 0x8 → all outputs 0 immediately; after release, lw 0x8 → 0. Also cover address 0x1000 wrapping to word 0 when DM_WORDS=1024.
